store_narrow: RTL and testbench

Store-path narrowing unit for the multi-cycle MIPS datapath: the write-side counterpart of load-data sign/zero extension. It takes a 32-bit register value plus a store size (`sb`/`sh`/`sw`) and commits only the addressed byte or halfword lanes to a word-only data memory. Sub-word stores are done by read-modify-write. It sits between the store-issue state of the control unit and the data RAM port.

---
 rtl/store_pkg.sv | 49 ++++
 rtl/store_narrow_lane_merge.sv | 33 +++
 rtl/store_narrow.sv | 113 +++++++++++
 tb/tb_store_narrow.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/store_pkg.sv
// Shared types and helpers for the store narrowing path.
// Latency: none, this file holds declarations and pure functions only.
// Backpressure: not applicable.
package store_pkg;

    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } size_e;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        WRITE = 3'd2,
        DONE  = 3'd3,
        FAULT = 3'd4
    } state_e;

    // Byte lanes touched by a store of the given size at byte offset a.
    function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] a);
        logic [3:0] m;
        m = 4'b0000;
        case (size)
            SZ_BYTE: m = 4'b0001 << a;
            SZ_HALF: m = a[1] ? 4'b1100 : 4'b0011;
            SZ_WORD: m = 4'b1111;
            default: m = 4'b0000;
        endcase
        return m;
    endfunction

    // A request is legal when its size is defined and it is naturally aligned.
    function automatic logic is_legal(input logic [1:0] size, input logic [1:0] a);
        logic ok;
        ok = 1'b0;
        case (size)
            SZ_BYTE: ok = 1'b1;
            SZ_HALF: ok = (a[0] == 1'b0);
            SZ_WORD: ok = (a == 2'b00);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/store_narrow_lane_merge.sv
// Merges store data into the addressed byte/halfword lanes of an old word.
// Latency: purely combinational.
// Backpressure: none, no handshake on this block.
module lane_merge
    import store_pkg::*;
(
    input  logic [31:0] old_word,
    input  logic [31:0] data,
    input  logic [1:0]  size,
    input  logic [1:0]  addr_lo,
    output logic [31:0] merged
);

    logic [3:0]  mask;
    logic [31:0] src;

    // Replicate the store data across lanes so each lane can pick it directly,
    // then take new or old data per byte according to the lane mask.
    always_comb begin
        mask   = lane_mask(size, addr_lo);
        src    = data;
        merged = old_word;
        case (size)
            SZ_BYTE: src = {4{data[7:0]}};
            SZ_HALF: src = {2{data[15:0]}};
            default: src = data;
        endcase
        for (int i = 0; i < 4; i++) begin
            merged[8*i +: 8] = mask[i] ? src[8*i +: 8] : old_word[8*i +: 8];
        end
    end

endmodule

// File: rtl/store_narrow.sv
// Narrows sb/sh/sw stores onto a word-only RAM via read-modify-write.
// Latency: word store done at T+2, sub-word at T+3, plus one cycle per memory wait.
// Backpressure: req_ready low while a store is in flight; mem_rd/mem_wr held until rvalid/wack.
module store_narrow
    import store_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_data,
    input  logic [1:0]        req_size,
    output logic              done,
    output logic              misalign,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_rvalid,
    output logic              mem_wr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_wack
);

    state_e            state_q;
    state_e            state_d;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [31:0]       mem_wdata_q;
    logic [31:0]       data_q;
    logic [1:0]        size_q;
    logic [1:0]        addr_lo_q;
    logic [31:0]       merged;
    logic              accept;
    logic              legal;

    assign accept = req_valid && (state_q == IDLE);
    assign legal  = is_legal(req_size, req_addr[1:0]);

    lane_merge u_lane_merge (
        .old_word (mem_rdata),
        .data     (data_q),
        .size     (size_q),
        .addr_lo  (addr_lo_q),
        .merged   (merged)
    );

    // State register; reset drops any pending access immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; stray rvalid/wack outside READ/WRITE fall through unused.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    if (!legal) begin
                        state_d = FAULT;
                    end else if (req_size == SZ_WORD) begin
                        state_d = WRITE;
                    end else begin
                        state_d = READ;
                    end
                end
            end
            READ:  if (mem_rvalid) state_d = WRITE;
            WRITE: if (mem_wack)   state_d = DONE;
            DONE:  state_d = IDLE;
            FAULT: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Latched request and memory-side address/data; only legal requests touch them,
    // so a rejected store leaves the RAM port untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            data_q      <= '0;
            size_q      <= 2'b00;
            addr_lo_q   <= 2'b00;
        end else if (accept && legal) begin
            mem_addr_q <= {req_addr[ADDR_W-1:2], 2'b00};
            data_q     <= req_data;
            size_q     <= req_size;
            addr_lo_q  <= req_addr[1:0];
            if (req_size == SZ_WORD) begin
                mem_wdata_q <= req_data;
            end
        end else if ((state_q == READ) && mem_rvalid) begin
            mem_wdata_q <= merged;
        end
    end

    // Control outputs are decodes of the state flop, so no mem_* input reaches
    // a mem_* output combinationally and rd/wr are mutually exclusive.
    assign req_ready = (state_q == IDLE);
    assign mem_rd    = (state_q == READ);
    assign mem_wr    = (state_q == WRITE);
    assign done      = (state_q == DONE);
    assign misalign  = (state_q == FAULT);
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_store_narrow.sv
// Directed bench for store_narrow: word, byte, half stores, rejects, reset, strays.
// Latency: checks each cycle at the falling edge against hand-computed values.
// Backpressure: bench plays the RAM, driving mem_rvalid/mem_wack per step.
module tb_store_narrow;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [31:0] req_data;
    logic [1:0]  req_size;
    logic        done;
    logic        misalign;
    logic [31:0] mem_addr;
    logic        mem_rd;
    logic [31:0] mem_rdata;
    logic        mem_rvalid;
    logic        mem_wr;
    logic [31:0] mem_wdata;
    logic        mem_wack;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int rd_cnt    = 0;
    int wr_cnt    = 0;
    int done_cnt  = 0;
    int both_cnt  = 0;
    int lowbits_bad = 0;

    store_narrow #(.ADDR_W(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .req_data   (req_data),
        .req_size   (req_size),
        .done       (done),
        .misalign   (misalign),
        .mem_addr   (mem_addr),
        .mem_rd     (mem_rd),
        .mem_rdata  (mem_rdata),
        .mem_rvalid (mem_rvalid),
        .mem_wr     (mem_wr),
        .mem_wdata  (mem_wdata),
        .mem_wack   (mem_wack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Per-cycle activity counters on the memory side.
    always @(posedge clk) begin
        if (mem_rd) rd_cnt++;
        if (mem_wr) wr_cnt++;
        if (done) done_cnt++;
        if (mem_rd && mem_wr) both_cnt++;
        if (mem_addr[1:0] != 2'b00) lowbits_bad++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Present a request for one cycle; returns at the falling edge of T+1.
    task automatic issue(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
        req_valid = 1'b1;
        req_addr  = a;
        req_data  = d;
        req_size  = s;
        step();
        req_valid = 1'b0;
    endtask

    int rd_before;
    int wr_before;
    int done_before;
    logic [31:0] bad_addr [3];
    logic [1:0]  bad_size [3];

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_addr = '0; req_data = '0; req_size = 2'b00;
        mem_rdata = '0; mem_rvalid = 1'b0; mem_wack = 1'b0;
        bad_addr[0] = 32'h201; bad_size[0] = 2'b01;
        bad_addr[1] = 32'h102; bad_size[1] = 2'b10;
        bad_addr[2] = 32'h100; bad_size[2] = 2'b11;

        // Reset values
        step();
        check("rst_ready", req_ready, 1);
        check("rst_rd", mem_rd, 0);
        check("rst_wr", mem_wr, 0);
        check("rst_done", done, 0);
        check("rst_misalign", misalign, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_wdata", mem_wdata, 0);
        rst_n = 1'b1;
        step();

        // sw 0xDEADBEEF @0x100, same-cycle wack
        mem_wack = 1'b1;
        issue(32'h100, 32'hDEADBEEF, 2'b10);
        check("sw_wr", mem_wr, 1);
        check("sw_rd", mem_rd, 0);
        check("sw_addr", mem_addr, 32'h100);
        check("sw_wdata", mem_wdata, 32'hDEADBEEF);
        check("sw_busy", req_ready, 0);
        check("sw_done_early", done, 0);
        step();
        check("sw_done", done, 1);
        check("sw_wr_drop", mem_wr, 0);
        mem_wack = 1'b0;
        step();
        check("sw_done_pulse", done, 0);
        check("sw_ready_back", req_ready, 1);
        check("sw_no_rd", rd_cnt, 0);
        check("sw_one_wr", wr_cnt, 1);

        // sb 0x123456AB @0x103 over 0x11223344
        mem_rdata = 32'h11223344; mem_rvalid = 1'b1; mem_wack = 1'b1;
        issue(32'h103, 32'h123456AB, 2'b00);
        check("sb_rd", mem_rd, 1);
        check("sb_wr_low", mem_wr, 0);
        check("sb_addr", mem_addr, 32'h100);
        step();
        check("sb_wr", mem_wr, 1);
        check("sb_rd_low", mem_rd, 0);
        check("sb_wdata", mem_wdata, 32'hAB223344);
        step();
        check("sb_done", done, 1);
        mem_rvalid = 1'b0; mem_wack = 1'b0;
        step();
        check("sb_ready_back", req_ready, 1);

        // sh 0xFFFFCAFE @0x202 over 0x11223344, rvalid two cycles late
        mem_wack = 1'b1;
        issue(32'h202, 32'hFFFFCAFE, 2'b01);
        check("sh_rd_t1", mem_rd, 1);
        step();
        check("sh_rd_t2", mem_rd, 1);
        check("sh_no_done_t2", done, 0);
        step();
        mem_rvalid = 1'b1;
        check("sh_rd_t3", mem_rd, 1);
        step();
        mem_rvalid = 1'b0;
        check("sh_wr_t4", mem_wr, 1);
        check("sh_addr", mem_addr, 32'h200);
        check("sh_wdata", mem_wdata, 32'hCAFE3344);
        step();
        check("sh_done_t5", done, 1);
        mem_wack = 1'b0;
        step();

        // Rejected requests: no memory access at all
        rd_before = rd_cnt;
        wr_before = wr_cnt;
        for (int i = 0; i < 3; i++) begin
            issue(bad_addr[i], 32'hFFFF_FFFF, bad_size[i]);
            check("bad_misalign", misalign, 1);
            check("bad_busy", req_ready, 0);
            check("bad_rd", mem_rd, 0);
            check("bad_wr", mem_wr, 0);
            step();
            check("bad_misalign_pulse", misalign, 0);
            check("bad_ready_back", req_ready, 1);
        end
        check("bad_rd_cnt", rd_cnt, rd_before);
        check("bad_wr_cnt", wr_cnt, wr_before);

        // Reset in WRITE with wack withheld
        issue(32'h300, 32'h55AA55AA, 2'b10);
        check("rstw_wr", mem_wr, 1);
        done_before = done_cnt;
        #2 rst_n = 1'b0;
        #1;
        check("rstw_wr_drop", mem_wr, 0);
        check("rstw_ready", req_ready, 1);
        check("rstw_addr", mem_addr, 0);
        check("rstw_wdata", mem_wdata, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check("rstw_idle_wr", mem_wr, 0);
        check("rstw_no_done", done_cnt, done_before);

        // Following sb 0xC3 @0x401 over 0xFFFFFFFF completes normally
        mem_rdata = 32'hFFFFFFFF; mem_rvalid = 1'b1; mem_wack = 1'b1;
        issue(32'h401, 32'h000000C3, 2'b00);
        check("sb2_rd", mem_rd, 1);
        step();
        check("sb2_wr", mem_wr, 1);
        check("sb2_addr", mem_addr, 32'h400);
        check("sb2_wdata", mem_wdata, 32'hFFFFC3FF);
        step();
        check("sb2_done", done, 1);
        mem_rvalid = 1'b0; mem_wack = 1'b0;
        step();

        // Stray rvalid/wack while idle
        mem_rvalid = 1'b1; mem_wack = 1'b1;
        step();
        step();
        check("stray_ready", req_ready, 1);
        check("stray_rd", mem_rd, 0);
        check("stray_wr", mem_wr, 0);
        check("stray_done", done, 0);
        check("stray_misalign", misalign, 0);
        mem_rvalid = 1'b0; mem_wack = 1'b0;
        step();

        check("rd_wr_exclusive", both_cnt, 0);
        check("addr_aligned", lowbits_bad, 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
